// File: rtl/pb_entry_pkg.sv
// rtl/pb_entry_pkg.sv - key map, FSM state and word-size constants for the pushbutton entry loader
package pb_entry_pkg;

  localparam int NUM_KEYS   = 21;
  localparam int KEY_W      = 5;
  localparam int WORD_BYTES = 4;

  localparam logic [KEY_W-1:0] KEY_BKSP    = 5'd16;
  localparam logic [KEY_W-1:0] KEY_CLR     = 5'd17;
  localparam logic [KEY_W-1:0] KEY_ENTER   = 5'd18;
  localparam logic [KEY_W-1:0] KEY_PTR_RST = 5'd19;
  localparam logic [KEY_W-1:0] KEY_RUN     = 5'd20;

  typedef enum logic {
    IDLE,
    WRITE
  } state_e;

endpackage

// File: rtl/pb_debounce.sv
// rtl/pb_debounce.sv - two-flop synchronizer, whole-vector debounce and rising-edge pulses
module pb_debounce #(
  parameter int WIDTH           = 21,
  parameter int DEBOUNCE_CYCLES = 120000
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic [WIDTH-1:0] pb_raw,
  output logic [WIDTH-1:0] stable,
  output logic [WIDTH-1:0] rise
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync1_q, sync2_q, prev_q;
  logic [WIDTH-1:0] stable_q, stable_d, stable_dly_q;
  logic [CW-1:0]    cnt_q, cnt_d;

  // Any change anywhere in the vector restarts the settle window for all bits.
  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    if (sync2_q != prev_q) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CW'(1);
    end
    if ((sync2_q == prev_q) && (cnt_d == CNT_MAX)) begin
      stable_d = sync2_q;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      prev_q       <= '0;
      cnt_q        <= '0;
      stable_q     <= '0;
      stable_dly_q <= '0;
    end else begin
      sync1_q      <= pb_raw;
      sync2_q      <= sync1_q;
      prev_q       <= sync2_q;
      cnt_q        <= cnt_d;
      stable_q     <= stable_d;
      stable_dly_q <= stable_q;
    end
  end

  assign stable = stable_q;
  assign rise   = stable_q & ~stable_dly_q;

endmodule

// File: rtl/pb_entry_loader.sv
// rtl/pb_entry_loader.sv - decodes debounced presses into hex entry and handshaked memory writes
module pb_entry_loader
  import pb_entry_pkg::*;
#(
  parameter int          DEBOUNCE_CYCLES = 120000,
  parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
  parameter int          MAX_WORDS       = 256
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic [20:0] pb,
  output logic [31:0] entry_value,
  output logic        mem_en,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  output logic [8:0]  word_count,
  output logic        busy,
  output logic        run_cpu
);

  localparam logic [31:0] LAST_ADDR = BASE_ADDR + 32'((MAX_WORDS - 1) * WORD_BYTES);
  localparam logic [8:0]  COUNT_MAX = 9'(MAX_WORDS);

  logic [NUM_KEYS-1:0] stable, rise;
  logic                key_valid;
  logic [KEY_W-1:0]    key_idx;

  state_e      state_q, state_d;
  logic [31:0] entry_value_q, entry_value_d;
  logic        mem_en_q, mem_en_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [8:0]  word_count_q, word_count_d;
  logic        busy_q, busy_d;
  logic        run_cpu_q, run_cpu_d;

  pb_debounce #(
    .WIDTH          (NUM_KEYS),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk   (clk),
    .nrst  (nrst),
    .pb_raw(pb),
    .stable(stable),
    .rise  (rise)
  );

  // Ascending scan so the highest simultaneous rising key overrides the rest.
  always_comb begin
    key_valid = 1'b0;
    key_idx   = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (rise[i]) begin
        key_valid = 1'b1;
        key_idx   = KEY_W'(i);
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    entry_value_d = entry_value_q;
    mem_en_d      = mem_en_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    word_count_d  = word_count_q;
    busy_d        = busy_q;
    run_cpu_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (key_valid) begin
          if (key_idx < KEY_BKSP) begin
            entry_value_d = {entry_value_q[27:0], key_idx[3:0]};
          end else begin
            case (key_idx)
              KEY_BKSP:    entry_value_d = entry_value_q >> 4;
              KEY_CLR:     entry_value_d = '0;
              KEY_ENTER: begin
                mem_wdata_d = entry_value_q;
                mem_en_d    = 1'b1;
                busy_d      = 1'b1;
                state_d     = WRITE;
              end
              KEY_PTR_RST: begin
                mem_addr_d   = BASE_ADDR;
                word_count_d = '0;
              end
              KEY_RUN:     run_cpu_d = 1'b1;
              default:     ;
            endcase
          end
        end
      end
      WRITE: begin
        // Presses seen here are dropped; only the ack moves the FSM on.
        if (mem_ack) begin
          mem_en_d      = 1'b0;
          busy_d        = 1'b0;
          entry_value_d = '0;
          state_d       = IDLE;
          if (word_count_q != COUNT_MAX) word_count_d = word_count_q + 9'd1;
          mem_addr_d = (mem_addr_q == LAST_ADDR) ? BASE_ADDR
                                                 : mem_addr_q + 32'(WORD_BYTES);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q       <= IDLE;
      entry_value_q <= '0;
      mem_en_q      <= 1'b0;
      mem_addr_q    <= BASE_ADDR;
      mem_wdata_q   <= '0;
      word_count_q  <= '0;
      busy_q        <= 1'b0;
      run_cpu_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      entry_value_q <= entry_value_d;
      mem_en_q      <= mem_en_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      word_count_q  <= word_count_d;
      busy_q        <= busy_d;
      run_cpu_q     <= run_cpu_d;
    end
  end

  assign entry_value = entry_value_q;
  assign mem_en      = mem_en_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign word_count  = word_count_q;
  assign busy        = busy_q;
  assign run_cpu     = run_cpu_q;

endmodule

// File: tb/tb_pb_entry_loader.sv
// tb/tb_pb_entry_loader.sv - directed self-checking bench for pb_entry_loader
module tb_pb_entry_loader;

  localparam logic [31:0] BASE = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic [20:0] pb = '0;
  logic        mem_ack = 1'b0;
  logic [31:0] entry_value, mem_addr, mem_wdata;
  logic        mem_en, busy, run_cpu;
  logic [8:0]  word_count;

  int vectors = 0;
  int errors  = 0;
  int en_cycles = 0, run_cycles = 0, changes = 0;
  logic [31:0] last_entry = '0;

  pb_entry_loader #(
    .DEBOUNCE_CYCLES(4),
    .BASE_ADDR      (BASE),
    .MAX_WORDS      (2)
  ) dut (
    .clk        (clk),
    .nrst       (nrst),
    .pb         (pb),
    .entry_value(entry_value),
    .mem_en     (mem_en),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .word_count (word_count),
    .busy       (busy),
    .run_cpu    (run_cpu)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (mem_en) en_cycles++;
    if (run_cpu) run_cycles++;
    if (entry_value != last_entry) changes++;
    last_entry = entry_value;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [20:0] bits);
    pb = bits;
    idle(10);
    pb = '0;
    idle(12);
  endtask

  task automatic key(input int k);
    logic [20:0] one;
    one = 21'd1;
    press(one << k);
  endtask

  task automatic wait_en(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      if (mem_en) seen = 1'b1;
    end
    chk("mem_en_seen", {31'd0, seen}, 32'd1);
  endtask

  int base_c, base_e, base_r;
  bit seen;
  int digits[9] = '{12, 13, 14, 10, 13, 11, 14, 14, 15};

  initial begin
    idle(3);
    chk("rst_entry", entry_value, 32'h0);
    chk("rst_en", {31'd0, mem_en}, 32'd0);
    chk("rst_addr", mem_addr, BASE);
    chk("rst_wdata", mem_wdata, 32'h0);
    chk("rst_count", {23'd0, word_count}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_run", {31'd0, run_cpu}, 32'd0);
    nrst = 1'b1;
    idle(8);

    base_c = changes;
    key(1);  chk("dig_1", entry_value, 32'h0000_0001);
    key(2);  chk("dig_2", entry_value, 32'h0000_0012);
    key(10); chk("dig_a", entry_value, 32'h0000_012A);
    key(11); chk("dig_b", entry_value, 32'h0000_12AB);
    chk("dig_updates", changes - base_c, 4);

    base_c = changes;
    for (int i = 0; i < 10; i++) begin
      pb[5] = ~pb[5];
      idle(2);
    end
    pb = '0;
    idle(12);
    chk("bounce_entry", entry_value, 32'h0000_12AB);
    chk("bounce_updates", changes - base_c, 0);

    key(16); chk("bksp", entry_value, 32'h0000_012A);
    key(17); chk("clear", entry_value, 32'h0);
    foreach (digits[i]) key(digits[i]);
    chk("overflow_entry", entry_value, 32'hDEAD_BEEF);

    mem_ack = 1'b1;
    base_e = en_cycles;
    pb = 21'd1 << 18;
    wait_en(seen);
    chk("w0_addr", mem_addr, BASE);
    chk("w0_wdata", mem_wdata, 32'hDEAD_BEEF);
    chk("w0_busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    chk("w0_en_low", {31'd0, mem_en}, 32'd0);
    chk("w0_busy_low", {31'd0, busy}, 32'd0);
    chk("w0_next_addr", mem_addr, BASE + 32'd4);
    chk("w0_count", {23'd0, word_count}, 32'd1);
    chk("w0_entry", entry_value, 32'h0);
    pb = '0;
    idle(12);
    chk("w0_en_cycles", en_cycles - base_e, 1);

    mem_ack = 1'b0;
    key(5);
    chk("w1_entry", entry_value, 32'h5);
    pb = 21'd1 << 18;
    wait_en(seen);
    pb = 21'd1 << 3;
    for (int i = 0; i < 12; i++) begin
      chk("w1_hold_en", {31'd0, mem_en}, 32'd1);
      chk("w1_hold_addr", mem_addr, BASE + 32'd4);
      chk("w1_hold_wdata", mem_wdata, 32'h5);
      @(negedge clk);
    end
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("w1_en_low", {31'd0, mem_en}, 32'd0);
    chk("w1_entry_zero", entry_value, 32'h0);
    chk("w1_wrap_addr", mem_addr, BASE);
    chk("w1_count", {23'd0, word_count}, 32'd2);
    idle(4);
    pb = '0;
    idle(12);
    chk("w1_drop_pb3", entry_value, 32'h0);

    key(7);
    mem_ack = 1'b1;
    pb = 21'd1 << 18;
    wait_en(seen);
    chk("w2_addr", mem_addr, BASE);
    chk("w2_wdata", mem_wdata, 32'h7);
    @(negedge clk);
    chk("w2_count_sat", {23'd0, word_count}, 32'd2);
    chk("w2_next_addr", mem_addr, BASE + 32'd4);
    pb = '0;
    idle(12);

    key(19);
    chk("ptr_rst_count", {23'd0, word_count}, 32'd0);
    chk("ptr_rst_addr", mem_addr, BASE);

    key(6);
    base_r = run_cycles;
    press((21'd1 << 20) | (21'd1 << 7));
    chk("run_pulses", run_cycles - base_r, 1);
    chk("run_entry", entry_value, 32'h6);

    pb = 21'd1 << 18;
    wait_en(seen);
    pb = '0;
    idle(12);
    chk("w3_addr_after", mem_addr, BASE + 32'd4);
    chk("w3_count", {23'd0, word_count}, 32'd1);

    mem_ack = 1'b0;
    key(9);
    pb = 21'd1 << 18;
    wait_en(seen);
    chk("w4_wdata", mem_wdata, 32'h9);
    idle(2);
    nrst = 1'b0;
    #1;
    chk("arst_en", {31'd0, mem_en}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_addr", mem_addr, BASE);
    chk("arst_wdata", mem_wdata, 32'h0);
    chk("arst_count", {23'd0, word_count}, 32'd0);
    chk("arst_entry", entry_value, 32'h0);
    chk("arst_run", {31'd0, run_cpu}, 32'd0);
    pb = '0;
    idle(3);
    nrst = 1'b1;
    idle(12);
    chk("post_rst_en", {31'd0, mem_en}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
